// File: rtl/mult_stream_collector.sv
// mult_stream_collector: valid/ready adapter around a fixed-latency,
// non-stalling pipelined multiplier, with credit-gated issue and result FIFO.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   in_valid/in_ready   operand pair handshake (in_a, in_b)
//   mul_a, mul_b        registered operands driven into the multiplier
//   mul_y               multiplier product, sampled LATENCY edges after issue
//   out_valid/out_ready result handshake, out_y is the FIFO head product
module mult_stream_collector #(
    parameter int WIDTH   = 48,
    parameter int LATENCY = 49,
    parameter int DEPTH   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_y
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < LATENCY + 1) begin : g_depth_check
        $error("mult_stream_collector: DEPTH must be >= LATENCY+1");
    end
    if (LATENCY < 2) begin : g_latency_check
        $error("mult_stream_collector: LATENCY must be >= 2");
    end

    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [LATENCY-1:0] vpipe_q, vpipe_d;
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW-1:0]      rptr_q, rptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      occ_q, occ_d;
    logic [2*WIDTH-1:0] mem [DEPTH];

    logic accept;
    logic pop;
    logic push;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        // Credit covers in-flight plus buffered products, so a push
        // can never find the FIFO full.
        in_ready  = ~rst & (occ_q < CW'(DEPTH));
        out_valid = (cnt_q != '0);
        out_y     = out_valid ? mem[rptr_q] : '0;
        accept    = in_valid & in_ready;
        pop       = out_valid & out_ready;
        // Only stages tagged valid are captured; stale mul_y is ignored.
        push      = vpipe_q[LATENCY-1];

        mul_a_d = accept ? in_a : mul_a_q;
        mul_b_d = accept ? in_b : mul_b_q;
        vpipe_d = {vpipe_q[LATENCY-2:0], accept};
        wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = pop  ? ptr_inc(rptr_q) : rptr_q;
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        occ_d   = occ_q + CW'(accept) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
            vpipe_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            occ_q   <= '0;
        end else begin
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            vpipe_q <= vpipe_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            occ_q   <= occ_d;
        end
    end

    // Storage needs no reset: entries are only read below the count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wptr_q] <= mul_y;
        end
    end

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;

endmodule
